wb_stage_arb: RTL and testbench
===============================

Name: wb_stage_arb

Overview:
- Parametrised write-back stage for the in-order RISC-V pipeline.
- Accepts one instruction per cycle from MEM over a valid/allowin handshake and formats load data (size, sign, byte offset).
- Arbitrates the single register-file write port between the in-order pipeline and a long-latency unit (mul/div) result channel, with a starvation guard.
- Counts retired instructions and drives the register-file write and forwarding bus.

Parameters:
- XLEN, 64, datapath width; 32 or 64.
- COUNT_W, 64, retired-instruction counter width.
- STARVE_MAX, 4, consecutive pipeline stall cycles before the pipeline gets write-port priority; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ms_to_ws_valid  in  1  MEM has an instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  XLEN  instruction PC
- ms_inst  in  32  instruction word
- ms_rf_wen  in  1  instruction writes rd
- ms_rd  in  5  destination register
- ms_wsel  in  2  write-data source
- ms_alu  in  XLEN  ALU result
- ms_rdata  in  XLEN  raw memory read data
- ms_ld_size  in  2  0=B, 1=H, 2=W, 3=D
- ms_ld_uns  in  1  zero-extend load
- ms_addr_lo  in  $clog2(XLEN/8)  load byte offset
- ll_valid  in  1  long-latency result available
- ll_ready  out  1  result accepted this cycle
- ll_rd  in  5  long-latency destination
- ll_data  in  XLEN  long-latency result
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- ws_valid_o  out  1  WB holds a valid instruction
- ws_pc  out  XLEN  PC of the held instruction
- ws_inst  out  32  instruction of the held instruction
- instret  out  COUNT_W  retired count

Behaviour:
- Reset (rst=1 sampled at clk edge):
  - ws_valid=0, instret=0, starve counter=0, prio=0.
  - Outputs after reset: rf_wen=0, ll_ready=0 unless ll_valid=1, ws_valid_o=0, ws_allowin=1, rf_waddr/rf_wdata=0.
- Handshake:
  - ws_allowin = !ws_valid || ws_ready_go.
  - The payload register loads when ms_to_ws_valid && ws_allowin.
  - ws_valid <= ms_to_ws_valid when ws_allowin.
  - Latency MEM->RF write is 1 cycle, or more when stalled.
- Write-data select (ms_wsel, registered):
  - ALU=00 -> alu.
  - RAM=01 -> formatted load.
  - PC4=10 -> pc+4, modulo 2^XLEN.
  - 11 -> 0.
- Load format:
  - Shift rdata right by addr_lo*8, then take byte/half/word/dword.
  - Sign-extend unless ld_uns.
  - With XLEN=32, size 3 is treated as word.
- Arbitration, per cycle:
  - pw = ws_valid && ws_rf_wen.
  - If ll_valid and (!pw or !prio): LL owns the port; rf_wen=1, ll_ready=1, and a pw instruction stalls (ws_ready_go=0).
  - Otherwise the pipeline owns the port: rf_wen=pw, ll_ready=0.
  - An instruction with ws_rf_wen=0 never stalls; ll_ready=1 in the same cycle if ll_valid.
  - Writes to x0 are suppressed (rf_wen=0) but still complete the handshake.
- Starvation guard:
  - The counter increments on each pw stall cycle.
  - When it reaches STARVE_MAX, prio=1.
  - The next cycle the pipeline writes; the counter and prio clear.
  - The counter also clears on any non-stalled cycle.
- instret increments by 1 when ws_valid && ws_ready_go; wraps at 2^COUNT_W.
- Ordering: WAW between the LL unit and younger pipeline writes to the same rd is prevented upstream by the issue scoreboard; WB does not check for it.
- ws_valid_o, ws_pc and ws_inst reflect the held entry, including while stalled.

Optional Feature:
- WB_COMMIT_TRACE_EN. When defined, adds the following outputs:
  - commit_valid: 1 cycle per retirement.
  - commit_pc, commit_inst.
  - commit_wen/commit_rd/commit_wdata: the pipeline's own write, or 0 if none.
  - ll_commit_valid with ll_rd/ll_data on each LL write.
- Purpose: difftest.
- When undefined, these ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared package holds:
  - WSEL_ALU/WSEL_RAM/WSEL_PC4 encodings.
  - LD_B/H/W/D size codes.
  - The ms_to_ws field widths and offsets, as a function of XLEN.
- Sub-module wb_load_fmt is purely combinational and instantiated once: rdata, size, uns, addr_lo -> formatted data.

Test Plan:
- XLEN=64; load ld_size=0, uns=0, addr_lo=3, rdata=0x0000_0000_8000_0000 -> rf_wdata=0xFFFF_FFFF_FFFF_FF80 one cycle after acceptance.
- wsel=PC4, pc=0xFFFF_FFFF_FFFF_FFFC, rd=5 -> rf_wdata=0, rf_waddr=5, instret +1.
- ll_valid with ll_rd=7, data=0x1234, while a pipeline instruction with rf_wen to rd=3 is held -> cycle 1: LL writes x7, ws_allowin=0; cycle 2: x3 written.
- ll_valid held high for 10 cycles, pipeline writes pending, STARVE_MAX=4 -> 4 LL writes, then 1 pipeline write, then LL resumes; no instruction lost.
- Back-to-back 8 instructions with ms_to_ws_valid=1, no LL traffic -> 8 writes in 8 cycles, instret=8.
- rst asserted mid-stall -> next cycle ws_valid_o=0, rf_wen=0, instret=0; the held instruction is dropped.

Source files
------------

// File: rtl/wb_stage_arb_pkg.sv
// Shared encodings and the ms_to_ws payload layout for the write-back stage.
// The layout helpers are functions of XLEN so every user agrees on field positions.
package wb_stage_arb_pkg;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_RAM  = 2'b01;
    localparam logic [1:0] WSEL_PC4  = 2'b10;
    localparam logic [1:0] WSEL_ZERO = 2'b11;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    localparam int RD_W    = 5;
    localparam int INST_W  = 32;
    localparam int STARVE_W = 4;

    function automatic int ws_addr_lo_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Payload is packed LSB first as: wdata, rd, rf_wen, inst, pc.
    function automatic int ws_rd_off(input int xlen);
        return xlen;
    endfunction

    function automatic int ws_wen_off(input int xlen);
        return xlen + RD_W;
    endfunction

    function automatic int ws_inst_off(input int xlen);
        return xlen + RD_W + 1;
    endfunction

    function automatic int ws_pc_off(input int xlen);
        return xlen + RD_W + 1 + INST_W;
    endfunction

    function automatic int ws_bus_w(input int xlen);
        return 2 * xlen + RD_W + 1 + INST_W;
    endfunction

endpackage

// File: rtl/wb_stage_arb_if.sv
// MEM->WB handshake, long-latency result channel and register-file write bus.
// Defining WB_COMMIT_TRACE_EN adds the difftest commit-trace signals.
interface wb_stage_arb_if #(
    parameter int XLEN    = 64,
    parameter int COUNT_W = 64
);
    import wb_stage_arb_pkg::*;

    localparam int AW = ws_addr_lo_w(XLEN);

    logic                ms_to_ws_valid;
    logic                ws_allowin;
    logic [XLEN-1:0]     ms_pc;
    logic [31:0]         ms_inst;
    logic                ms_rf_wen;
    logic [4:0]          ms_rd;
    logic [1:0]          ms_wsel;
    logic [XLEN-1:0]     ms_alu;
    logic [XLEN-1:0]     ms_rdata;
    logic [1:0]          ms_ld_size;
    logic                ms_ld_uns;
    logic [AW-1:0]       ms_addr_lo;

    logic                ll_valid;
    logic                ll_ready;
    logic [4:0]          ll_rd;
    logic [XLEN-1:0]     ll_data;

    logic                rf_wen;
    logic [4:0]          rf_waddr;
    logic [XLEN-1:0]     rf_wdata;

    logic                ws_valid_o;
    logic [XLEN-1:0]     ws_pc;
    logic [31:0]         ws_inst;
    logic [COUNT_W-1:0]  instret;

`ifdef WB_COMMIT_TRACE_EN
    logic                commit_valid;
    logic [XLEN-1:0]     commit_pc;
    logic [31:0]         commit_inst;
    logic                commit_wen;
    logic [4:0]          commit_rd;
    logic [XLEN-1:0]     commit_wdata;
    logic                ll_commit_valid;
    logic [4:0]          ll_commit_rd;
    logic [XLEN-1:0]     ll_commit_data;
`endif

    modport master (
`ifdef WB_COMMIT_TRACE_EN
        input  commit_valid, commit_pc, commit_inst, commit_wen, commit_rd,
               commit_wdata, ll_commit_valid, ll_commit_rd, ll_commit_data,
`endif
        output ms_to_ws_valid, ms_pc, ms_inst, ms_rf_wen, ms_rd, ms_wsel,
               ms_alu, ms_rdata, ms_ld_size, ms_ld_uns, ms_addr_lo,
               ll_valid, ll_rd, ll_data,
        input  ws_allowin, ll_ready, rf_wen, rf_waddr, rf_wdata,
               ws_valid_o, ws_pc, ws_inst, instret
    );

    modport slave (
`ifdef WB_COMMIT_TRACE_EN
        output commit_valid, commit_pc, commit_inst, commit_wen, commit_rd,
               commit_wdata, ll_commit_valid, ll_commit_rd, ll_commit_data,
`endif
        input  ms_to_ws_valid, ms_pc, ms_inst, ms_rf_wen, ms_rd, ms_wsel,
               ms_alu, ms_rdata, ms_ld_size, ms_ld_uns, ms_addr_lo,
               ll_valid, ll_rd, ll_data,
        output ws_allowin, ll_ready, rf_wen, rf_waddr, rf_wdata,
               ws_valid_o, ws_pc, ws_inst, instret
    );

endinterface

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: aligns raw read data by the byte offset, then
// extracts a byte/half/word/dword and sign- or zero-extends it to XLEN.
module wb_load_fmt
    import wb_stage_arb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = ws_addr_lo_w(XLEN)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [AW-1:0]   addr_lo,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sgn;

    // A dword request on a 32-bit datapath falls through to the word case.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        mask    = XLEN'(32'hFFFF_FFFF);
        sgn     = shifted[31];
        case (size)
            LD_B: begin
                mask = XLEN'(8'hFF);
                sgn  = shifted[7];
            end
            LD_H: begin
                mask = XLEN'(16'hFFFF);
                sgn  = shifted[15];
            end
            LD_D: begin
                if (XLEN > 32) begin
                    mask = '1;
                    sgn  = shifted[XLEN-1];
                end
            end
            default: ;
        endcase
        data = (shifted & mask) | ((sgn && !uns) ? ~mask : '0);
    end

endmodule

// File: rtl/wb_stage_arb.sv
// Write-back stage: registers one MEM instruction, arbitrates the RF write port
// against the long-latency unit with a starvation guard. Optional: WB_COMMIT_TRACE_EN.
module wb_stage_arb
    import wb_stage_arb_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int COUNT_W    = 64,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    wb_stage_arb_if.slave bus
);

    localparam int AW       = ws_addr_lo_w(XLEN);
    localparam int BUS_W    = ws_bus_w(XLEN);
    localparam int RD_OFF   = ws_rd_off(XLEN);
    localparam int WEN_OFF  = ws_wen_off(XLEN);
    localparam int INST_OFF = ws_inst_off(XLEN);
    localparam int PC_OFF   = ws_pc_off(XLEN);

    logic [XLEN-1:0]     ld_data;
    logic [XLEN-1:0]     ms_wdata;
    logic [BUS_W-1:0]    ms_to_ws_bus;
    logic [BUS_W-1:0]    ws_bus;
    logic                ws_valid;
    logic                prio;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic [COUNT_W-1:0]  instret_q;

    logic [XLEN-1:0]     ws_wdata;
    logic [4:0]          ws_rd;
    logic                ws_rf_wen;
    logic [31:0]         ws_inst_q;
    logic [XLEN-1:0]     ws_pc_q;

    logic                pw;
    logic                ll_wins;
    logic                pw_stall;
    logic                ws_ready_go;
    logic                allowin;

    wb_load_fmt #(.XLEN(XLEN), .AW(AW)) u_load_fmt (
        .rdata   (bus.ms_rdata),
        .size    (bus.ms_ld_size),
        .uns     (bus.ms_ld_uns),
        .addr_lo (bus.ms_addr_lo),
        .data    (ld_data)
    );

    // Write data is resolved before the payload register so WB only muxes ports.
    always_comb begin
        ms_wdata = '0;
        case (bus.ms_wsel)
            WSEL_ALU: ms_wdata = bus.ms_alu;
            WSEL_RAM: ms_wdata = ld_data;
            WSEL_PC4: ms_wdata = bus.ms_pc + XLEN'(4);
            default:  ms_wdata = '0;
        endcase
    end

    assign ms_to_ws_bus = {bus.ms_pc, bus.ms_inst, bus.ms_rf_wen, bus.ms_rd, ms_wdata};

    assign ws_wdata  = ws_bus[XLEN-1:0];
    assign ws_rd     = ws_bus[RD_OFF +: RD_W];
    assign ws_rf_wen = ws_bus[WEN_OFF];
    assign ws_inst_q = ws_bus[INST_OFF +: INST_W];
    assign ws_pc_q   = ws_bus[PC_OFF +: XLEN];

    // LL wins unless the pipeline has a pending write and has earned priority.
    assign pw          = ws_valid && ws_rf_wen;
    assign ll_wins     = bus.ll_valid && (!pw || !prio);
    assign pw_stall    = pw && ll_wins;
    assign ws_ready_go = !pw_stall;
    assign allowin     = !ws_valid || ws_ready_go;
    assign starve_nxt  = starve_cnt + STARVE_W'(1);

    always_comb begin
        bus.rf_wen   = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (ll_wins) begin
            bus.rf_wen   = (bus.ll_rd != 5'd0);
            bus.rf_waddr = bus.ll_rd;
            bus.rf_wdata = bus.ll_data;
        end else if (ws_valid) begin
            bus.rf_wen   = ws_rf_wen && (ws_rd != 5'd0);
            bus.rf_waddr = ws_rd;
            bus.rf_wdata = ws_wdata;
        end
    end

    assign bus.ll_ready   = ll_wins;
    assign bus.ws_allowin = allowin;
    assign bus.ws_valid_o = ws_valid;
    assign bus.ws_pc      = ws_pc_q;
    assign bus.ws_inst    = ws_inst_q;
    assign bus.instret    = instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_valid <= 1'b0;
            ws_bus   <= '0;
        end else if (allowin) begin
            ws_valid <= bus.ms_to_ws_valid;
            if (bus.ms_to_ws_valid) begin
                ws_bus <= ms_to_ws_bus;
            end
        end
    end

    // Priority flips after STARVE_MAX consecutive stalls and drops once the pipeline writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            prio       <= 1'b0;
        end else if (pw_stall) begin
            starve_cnt <= starve_nxt;
            if (starve_nxt == STARVE_W'(STARVE_MAX)) begin
                prio <= 1'b1;
            end
        end else begin
            starve_cnt <= '0;
            prio       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (ws_valid && ws_ready_go) begin
            instret_q <= instret_q + COUNT_W'(1);
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    logic commit_fire;
    logic commit_write;

    assign commit_fire      = ws_valid && ws_ready_go;
    assign commit_write     = commit_fire && ws_rf_wen && (ws_rd != 5'd0);

    assign bus.commit_valid    = commit_fire;
    assign bus.commit_pc       = ws_pc_q;
    assign bus.commit_inst     = ws_inst_q;
    assign bus.commit_wen      = commit_write;
    assign bus.commit_rd       = commit_write ? ws_rd : 5'd0;
    assign bus.commit_wdata    = commit_write ? ws_wdata : '0;
    assign bus.ll_commit_valid = ll_wins && (bus.ll_rd != 5'd0);
    assign bus.ll_commit_rd    = bus.ll_rd;
    assign bus.ll_commit_data  = bus.ll_data;
`endif

endmodule

// File: tb/tb_wb_stage_arb.sv
// Scoreboard bench for wb_stage_arb: expected RF writes are queued as stimulus is
// issued and a negedge monitor pops and compares every write the DUT performs.
module tb_wb_stage_arb;
    import wb_stage_arb_pkg::*;

    localparam int XLEN       = 64;
    localparam int COUNT_W    = 64;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    typedef struct packed {
        logic [1:0]      wsel;
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [1:0]      size;
        logic            uns;
        logic [2:0]      addr_lo;
        logic            writes;
        logic [XLEN-1:0] expv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t              exp_q[$];
    exp_t              mon_e;
    vec_t              vecs[12];
    int                tests_run = 0;
    int                fail_cnt  = 0;
    logic [COUNT_W-1:0] exp_instret = '0;

    wb_stage_arb_if #(.XLEN(XLEN), .COUNT_W(COUNT_W)) bus ();

    wb_stage_arb #(.XLEN(XLEN), .COUNT_W(COUNT_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every RF write must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && bus.rf_wen) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("[TB] FAIL rf_write: got x%0d=%h, required no write", bus.rf_waddr, bus.rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_waddr !== mon_e.rd || bus.rf_wdata !== mon_e.data) begin
                    fail_cnt++;
                    $display("[TB] FAIL rf_write: got x%0d=%h, required x%0d=%h",
                             bus.rf_waddr, bus.rf_wdata, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests_run++;
        if (actual !== required) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Presents one instruction and holds it until WB accepts it (bounded).
    task automatic applyStimulus(input vec_t v, output int waits);
        bus.ms_pc          = v.pc;
        bus.ms_inst        = 32'hA000_0000 | 32'(v.rd);
        bus.ms_rf_wen      = v.wen;
        bus.ms_rd          = v.rd;
        bus.ms_wsel        = v.wsel;
        bus.ms_alu         = v.alu;
        bus.ms_rdata       = v.rdata;
        bus.ms_ld_size     = v.size;
        bus.ms_ld_uns      = v.uns;
        bus.ms_addr_lo     = v.addr_lo;
        bus.ms_to_ws_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.ws_allowin && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.ws_allowin) begin
            tests_run++;
            fail_cnt++;
            $display("[TB] FAIL accept_timeout: got ws_allowin=0 for %0d cycles, required acceptance", waits);
        end
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] wsel, input logic wen, input logic [4:0] rd,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                                input logic [XLEN-1:0] rdata, input logic [1:0] size,
                                input logic uns, input logic [2:0] addr_lo,
                                input logic writes, input logic [XLEN-1:0] expv);
        vec_t v;
        v.wsel = wsel; v.wen = wen; v.rd = rd; v.pc = pc; v.alu = alu; v.rdata = rdata;
        v.size = size; v.uns = uns; v.addr_lo = addr_lo; v.writes = writes; v.expv = expv;
        return v;
    endfunction

    initial begin
        int   w;
        int   total;
        vec_t v;

        bus.ms_to_ws_valid = 1'b0;
        bus.ms_pc = '0; bus.ms_inst = '0; bus.ms_rf_wen = 1'b0; bus.ms_rd = '0;
        bus.ms_wsel = '0; bus.ms_alu = '0; bus.ms_rdata = '0; bus.ms_ld_size = '0;
        bus.ms_ld_uns = 1'b0; bus.ms_addr_lo = '0;
        bus.ll_valid = 1'b0; bus.ll_rd = '0; bus.ll_data = '0;

        vecs[0]  = mk(WSEL_RAM, 1, 5'd6,  64'h100, 64'h0, 64'h1234_8765_4321_ABCD, LD_H, 1, 3'd2, 1, 64'h0000_0000_0000_4321);
        vecs[1]  = mk(WSEL_RAM, 1, 5'd8,  64'h104, 64'h0, 64'h8765_4321_0000_0000, LD_W, 0, 3'd4, 1, 64'hFFFF_FFFF_8765_4321);
        vecs[2]  = mk(WSEL_RAM, 1, 5'd9,  64'h108, 64'h0, 64'h8765_4321_0000_0001, LD_D, 0, 3'd0, 1, 64'h8765_4321_0000_0001);
        vecs[3]  = mk(WSEL_RAM, 1, 5'd11, 64'h10C, 64'h0, 64'hF00D_0000_0000_0000, LD_H, 0, 3'd6, 1, 64'hFFFF_FFFF_FFFF_F00D);
        vecs[4]  = mk(WSEL_RAM, 1, 5'd12, 64'h110, 64'h0, 64'h8765_4321_0000_0000, LD_W, 1, 3'd4, 1, 64'h0000_0000_8765_4321);
        vecs[5]  = mk(WSEL_RAM, 1, 5'd18, 64'h114, 64'h0, 64'hAB00_0000_0000_0000, LD_B, 1, 3'd7, 1, 64'h0000_0000_0000_00AB);
        vecs[6]  = mk(WSEL_ALU, 1, 5'd13, 64'h118, 64'hDEAD_BEEF_0000_1111, 64'h0, LD_B, 0, 3'd0, 1, 64'hDEAD_BEEF_0000_1111);
        vecs[7]  = mk(WSEL_ZERO, 1, 5'd14, 64'h11C, 64'h5, 64'h0, LD_B, 0, 3'd0, 1, 64'h0);
        vecs[8]  = mk(WSEL_PC4, 1, 5'd5,  64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, LD_B, 0, 3'd0, 1, 64'h0);
        vecs[9]  = mk(WSEL_PC4, 1, 5'd16, 64'h0000_0000_8000_0000, 64'h0, 64'h0, LD_B, 0, 3'd0, 1, 64'h0000_0000_8000_0004);
        vecs[10] = mk(WSEL_ALU, 1, 5'd0,  64'h120, 64'h77, 64'h0, LD_B, 0, 3'd0, 0, 64'h0);
        vecs[11] = mk(WSEL_ALU, 0, 5'd17, 64'h124, 64'h99, 64'h0, LD_B, 0, 3'd0, 0, 64'h0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rf_wen",     64'(bus.rf_wen),     64'd0);
        checkOutput("reset_ll_ready",   64'(bus.ll_ready),   64'd0);
        checkOutput("reset_ws_valid_o", 64'(bus.ws_valid_o), 64'd0);
        checkOutput("reset_ws_allowin", 64'(bus.ws_allowin), 64'd1);
        checkOutput("reset_rf_waddr",   64'(bus.rf_waddr),   64'd0);
        checkOutput("reset_rf_wdata",   bus.rf_wdata,        64'd0);
        checkOutput("reset_instret",    bus.instret,         64'd0);
        @(posedge clk);
        #1;

        // Signed byte load at offset 3, visible one cycle after acceptance.
        v = mk(WSEL_RAM, 1, 5'd4, 64'h1000, 64'h0, 64'h0000_0000_8000_0000, LD_B, 0, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FF80);
        push_exp(v.rd, v.expv);
        applyStimulus(v, w);
        bus.ms_to_ws_valid = 1'b0;
        @(negedge clk);
        checkOutput("lb_rf_wen",   64'(bus.rf_wen),   64'd1);
        checkOutput("lb_rf_waddr", 64'(bus.rf_waddr), 64'd4);
        checkOutput("lb_rf_wdata", bus.rf_wdata,      64'hFFFF_FFFF_FFFF_FF80);
        drain();
        checkOutput("lb_instret", bus.instret, exp_instret);

        // Load formats, write-select sources, x0 and no-write instructions.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].writes) push_exp(vecs[i].rd, vecs[i].expv);
            applyStimulus(vecs[i], w);
        end
        bus.ms_to_ws_valid = 1'b0;
        drain();
        checkOutput("vec_instret", bus.instret, exp_instret);

        // LL result arrives while a pipeline write is held.
        push_exp(5'd7, 64'h1234);
        push_exp(5'd3, 64'h55);
        v = mk(WSEL_ALU, 1, 5'd3, 64'h2000, 64'h55, 64'h0, LD_B, 0, 3'd0, 1, 64'h55);
        applyStimulus(v, w);
        bus.ms_to_ws_valid = 1'b0;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_data = 64'h1234;
        @(negedge clk);
        checkOutput("ll_held_allowin",  64'(bus.ws_allowin), 64'd0);
        checkOutput("ll_held_ll_ready", 64'(bus.ll_ready),   64'd1);
        checkOutput("ll_held_valid_o",  64'(bus.ws_valid_o), 64'd1);
        checkOutput("ll_held_pc",       bus.ws_pc,           64'h2000);
        checkOutput("ll_held_inst",     64'(bus.ws_inst),    64'hA000_0003);
        @(posedge clk);
        #1 bus.ll_valid = 1'b0;
        @(negedge clk);
        checkOutput("ll_after_allowin", 64'(bus.ws_allowin), 64'd1);
        checkOutput("ll_after_waddr",   64'(bus.rf_waddr),   64'd3);
        drain();

        // Starvation guard: LL held for 10 cycles against two pending pipeline writes.
        repeat (4) push_exp(5'd10, 64'hC0FFEE);
        push_exp(5'd20, 64'hA);
        repeat (4) push_exp(5'd10, 64'hC0FFEE);
        push_exp(5'd21, 64'hB);
        v = mk(WSEL_ALU, 1, 5'd20, 64'h3000, 64'hA, 64'h0, LD_B, 0, 3'd0, 1, 64'hA);
        applyStimulus(v, w);
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd10; bus.ll_data = 64'hC0FFEE;
        v = mk(WSEL_ALU, 1, 5'd21, 64'h3004, 64'hB, 64'h0, LD_B, 0, 3'd0, 1, 64'hB);
        applyStimulus(v, w);
        bus.ms_to_ws_valid = 1'b0;
        checkOutput("starve_waits", 64'(w), 64'd4);
        repeat (5) @(posedge clk);
        #1 bus.ll_valid = 1'b0;
        drain();
        checkOutput("starve_instret", bus.instret, exp_instret);

        // Eight back-to-back instructions with no LL traffic.
        total = 0;
        for (int i = 0; i < 8; i++) begin
            v = mk(WSEL_ALU, 1, 5'(i + 1), 64'(64'h4000 + 4 * i), 64'(i * 17 + 1), 64'h0, LD_B, 0, 3'd0, 1, 64'(i * 17 + 1));
            push_exp(v.rd, v.expv);
            applyStimulus(v, w);
            total += w;
        end
        bus.ms_to_ws_valid = 1'b0;
        checkOutput("b2b_waits", 64'(total), 64'd0);
        drain();
        checkOutput("b2b_instret", bus.instret, exp_instret);

        // Reset in the middle of a stall drops the held instruction.
        push_exp(5'd13, 64'hBEEF);
        v = mk(WSEL_ALU, 1, 5'd12, 64'h5000, 64'h12, 64'h0, LD_B, 0, 3'd0, 1, 64'h12);
        applyStimulus(v, w);
        bus.ms_to_ws_valid = 1'b0;
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd13; bus.ll_data = 64'hBEEF;
        @(negedge clk);
        checkOutput("rst_stall_allowin", 64'(bus.ws_allowin), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ll_valid = 1'b0;
        exp_instret = '0;
        @(negedge clk);
        checkOutput("rst_valid_o", 64'(bus.ws_valid_o), 64'd0);
        checkOutput("rst_rf_wen",  64'(bus.rf_wen),     64'd0);
        checkOutput("rst_instret", bus.instret,         exp_instret);
        checkOutput("rst_allowin", 64'(bus.ws_allowin), 64'd1);
        drain();
        checkOutput("rst_instret_after", bus.instret, exp_instret);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
